// File: rtl/spi_tx_arbiter_pkg.sv
// Shared types and constants for the SPI transmit arbiter.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_LO,
    HOLD,
    GAP
  } arb_state_t;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_tx_arbiter_if.sv
// Client request/ack bus plus the byte-engine handshake seen by the SPI transmit arbiter.
interface spi_tx_arbiter_if
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) ();

  localparam int unsigned IdW = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [SPI_BYTE_W*NUM_REQ-1:0] wdata;
  logic [NUM_REQ-1:0]            last;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REQ-1:0]            cs_n;
  logic                          busy;
  logic [IdW-1:0]                grant_id;
  logic                          timeout_err;
  logic                          spi_load;
  logic [SPI_BYTE_W-1:0]         spi_byte;
  logic                          spi_done;

  // Arbiter side.
  modport slave (
    input  req, wdata, last, spi_done,
    output ack, cs_n, busy, grant_id, timeout_err, spi_load, spi_byte
  );

  // Clients and byte engine side.
  modport master (
    output req, wdata, last, spi_done,
    input  ack, cs_n, busy, grant_id, timeout_err, spi_load, spi_byte
  );

endinterface

// File: rtl/spi_tx_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdW = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdW-1:0]     ptr,
  output logic               grant_valid,
  output logic [IdW-1:0]     grant_idx
);

  localparam int unsigned SumW = IdW + 1;

  logic [SumW-1:0] scan;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr} + SumW'(k);
      if (scan >= SumW'(NUM_REQ)) begin
        scan = scan - SumW'(NUM_REQ);
      end
      if (!grant_valid && req[scan[IdW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = scan[IdW-1:0];
      end
    end
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Shares one byte-serial SPI engine among NUM_REQ clients, one chip select per client,
// round-robin per multi-byte transaction with lock and engine-done timeouts.
module spi_tx_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned CS_GAP       = 4,
  parameter int unsigned LOCK_TIMEOUT = 255,
  parameter int unsigned DONE_TIMEOUT = 1023
) (
  input logic             clock,
  input logic             reset,
  spi_tx_arbiter_if.slave bus
);

  localparam int unsigned IdW   = idx_width(NUM_REQ);
  localparam int unsigned GapW  = $clog2(CS_GAP + 1);
  localparam int unsigned LockW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned DoneW = $clog2(DONE_TIMEOUT + 1);

  localparam logic [GapW-1:0]  GapMax  = GapW'(CS_GAP - 1);
  localparam logic [LockW-1:0] LockMax = LockW'(LOCK_TIMEOUT - 1);
  localparam logic [DoneW-1:0] DoneMax = DoneW'(DONE_TIMEOUT - 1);
  localparam logic [IdW-1:0]   LastId  = IdW'(NUM_REQ - 1);

  arb_state_t            state_q, state_d;
  logic [IdW-1:0]        grant_q, grant_d;
  logic [IdW-1:0]        ptr_q, ptr_d;
  logic [SPI_BYTE_W-1:0] byte_q, byte_d;
  logic                  last_q, last_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic                  terr_q, terr_d;
  logic                  done_s1_q, done_s2_q;
  logic [DoneW-1:0]      done_cnt_q, done_cnt_d;
  logic [LockW-1:0]      lock_cnt_q, lock_cnt_d;
  logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;

  logic                  rr_valid;
  logic [IdW-1:0]        rr_idx;
  logic [SPI_BYTE_W-1:0] wbyte [NUM_REQ];
  logic [NUM_REQ-1:0]    cs_n;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign wbyte[g] = bus.wdata[g*SPI_BYTE_W +: SPI_BYTE_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req         (bus.req),
    .ptr         (ptr_q),
    .grant_valid (rr_valid),
    .grant_idx   (rr_idx)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      ack_q      <= '0;
      terr_q     <= 1'b0;
      done_s1_q  <= 1'b0;
      done_s2_q  <= 1'b0;
      done_cnt_q <= '0;
      lock_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      byte_q     <= byte_d;
      last_q     <= last_d;
      ack_q      <= ack_d;
      terr_q     <= terr_d;
      done_s1_q  <= bus.spi_done;
      done_s2_q  <= done_s1_q;
      done_cnt_q <= done_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    byte_d     = byte_q;
    last_d     = last_q;
    ack_d      = '0;
    terr_d     = 1'b0;
    done_cnt_d = done_cnt_q;
    lock_cnt_d = lock_cnt_q;
    gap_cnt_d  = gap_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (rr_valid) begin
          grant_d = rr_idx;
          byte_d  = wbyte[rr_idx];
          last_d  = bus.last[rr_idx];
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (done_s2_q) begin
          state_d = WAIT_LO;
        end else if (done_cnt_q == DoneMax) begin
          terr_d  = 1'b1;
          state_d = GAP;
        end else begin
          done_cnt_d = done_cnt_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!done_s2_q) begin
          ack_d[grant_q] = 1'b1;
          state_d        = last_q ? GAP : HOLD;
        end else if (done_cnt_q == DoneMax) begin
          terr_d  = 1'b1;
          state_d = GAP;
        end else begin
          done_cnt_d = done_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        // The ack cycle itself never starts a new byte; the owner is still dropping req.
        if ((ack_q == '0) && bus.req[grant_q]) begin
          byte_d  = wbyte[grant_q];
          last_d  = bus.last[grant_q];
          state_d = LOAD;
        end else if (lock_cnt_q == LockMax) begin
          terr_d  = 1'b1;
          state_d = GAP;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GapMax) begin
          state_d = IDLE;
          ptr_d   = (grant_q == LastId) ? '0 : grant_q + 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every counter restarts from zero on entry to a new state.
    if (state_d != state_q) begin
      done_cnt_d = '0;
      lock_cnt_d = '0;
      gap_cnt_d  = '0;
    end
  end

  always_comb begin
    cs_n = '1;
    if (state_q inside {LOAD, WAIT_LO, HOLD}) begin
      cs_n[grant_q] = 1'b0;
    end
  end

  assign bus.cs_n        = cs_n;
  assign bus.ack         = ack_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.grant_id    = grant_q;
  assign bus.timeout_err = terr_q;
  assign bus.spi_load    = (state_q == LOAD);
  assign bus.spi_byte    = byte_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Scoreboard bench for spi_tx_arbiter with a behavioural byte engine.
module tb_spi_tx_arbiter;
  import spi_pkg::*;

  localparam int unsigned N = 4;

  typedef struct {
    bit          is_to;
    int unsigned idx;
    logic [7:0]  data;
  } exp_t;

  logic clock;
  logic reset;
  exp_t exp_q[$];
  int   vectors;
  int   miscompares;
  logic [7:0] eng_byte;
  bit   eng_mute;
  int   k;

  spi_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  spi_tx_arbiter #(
    .NUM_REQ      (N),
    .CS_GAP       (4),
    .LOCK_TIMEOUT (255),
    .DONE_TIMEOUT (1023)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push_ack(input int unsigned i, input logic [7:0] d);
    exp_t e;
    e.is_to = 1'b0;
    e.idx   = i;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic push_to();
    exp_t e;
    e.is_to = 1'b1;
    e.idx   = 0;
    e.data  = 8'h00;
    exp_q.push_back(e);
  endtask

  // Client i presents one byte and holds req until its ack is seen.
  task automatic drive(input int unsigned i, input logic [7:0] d, input logic l);
    bit got;
    got = 1'b0;
    bus.req[i]          = 1'b1;
    bus.wdata[8*i +: 8] = d;
    bus.last[i]         = l;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clock);
      if (bus.ack[i]) got = 1'b1;
    end
    bus.req[i] = 1'b0;
    chk("ack_seen", 32'(got), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    bus.req      = '0;
    bus.wdata    = '0;
    bus.last     = '0;
    bus.spi_done = 1'b0;
    eng_mute     = 1'b0;
    eng_byte     = '0;
    vectors      = 0;
    miscompares  = 0;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clock);
          if (reset && (bus.ack != '0 || bus.timeout_err)) begin
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_event: ack=%b timeout_err=%b at %0t",
                       bus.ack, bus.timeout_err, $time);
            end else begin
              e = exp_q.pop_front();
              if (e.is_to) begin
                chk("timeout_err", 32'(bus.timeout_err), 32'd1);
                chk("timeout_no_ack", 32'(bus.ack), 32'd0);
              end else begin
                chk("ack_vec", 32'(bus.ack), 32'd1 << e.idx);
                chk("ack_byte", 32'(eng_byte), 32'(e.data));
                chk("ack_grant", 32'(bus.grant_id), e.idx);
              end
            end
          end
        end
      end
      begin : engine
        int cnt;
        forever begin
          @(negedge clock);
          if (bus.spi_load && !eng_mute) begin
            eng_byte = bus.spi_byte;
            cnt = 0;
            while (cnt < 40 && bus.spi_load) begin
              @(negedge clock);
              cnt++;
            end
            if (bus.spi_load) begin
              bus.spi_done = 1'b1;
              cnt = 0;
              while (bus.spi_load && cnt < 2000) begin
                @(negedge clock);
                cnt++;
              end
              repeat (2) @(negedge clock);
              bus.spi_done = 1'b0;
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_cs_n", 32'(bus.cs_n), 32'hF);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_load", 32'(bus.spi_load), 32'd0);
    chk("rst_byte", 32'(bus.spi_byte), 32'd0);
    chk("rst_grant", 32'(bus.grant_id), 32'd0);
    chk("rst_terr", 32'(bus.timeout_err), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Single byte from client 1
    push_ack(1, 8'hA5);
    fork
      drive(1, 8'hA5, 1'b1);
      begin
        @(negedge clock);
        chk("single_cs_n", 32'(bus.cs_n), 32'hD);
        chk("single_byte", 32'(bus.spi_byte), 32'hA5);
        chk("single_busy", 32'(bus.busy), 32'd1);
        chk("single_load", 32'(bus.spi_load), 32'd1);
      end
    join
    chk("gap_cs_n", 32'(bus.cs_n), 32'hF);
    chk("gap_busy_first", 32'(bus.busy), 32'd1);
    repeat (3) @(negedge clock);
    chk("gap_busy_last", 32'(bus.busy), 32'd1);
    @(negedge clock);
    chk("gap_done_busy", 32'(bus.busy), 32'd0);

    // Three-byte burst from client 2 while client 0 waits
    push_ack(2, 8'h11);
    push_ack(2, 8'h22);
    push_ack(2, 8'h33);
    push_ack(0, 8'h77);
    fork
      begin
        drive(2, 8'h11, 1'b0);
        chk("burst_cs_n_1", 32'(bus.cs_n), 32'hB);
        drive(2, 8'h22, 1'b0);
        chk("burst_cs_n_2", 32'(bus.cs_n), 32'hB);
        drive(2, 8'h33, 1'b1);
        repeat (4) @(negedge clock);
        chk("burst_gap_end_cs_n", 32'(bus.cs_n), 32'hF);
        @(negedge clock);
        chk("waiter_cs_n", 32'(bus.cs_n), 32'hE);
        chk("waiter_grant", 32'(bus.grant_id), 32'd0);
      end
      drive(0, 8'h77, 1'b1);
    join
    repeat (5) @(negedge clock);

    // Lock timeout: client 3 leaves an open transaction
    push_ack(3, 8'h3C);
    push_to();
    drive(3, 8'h3C, 1'b0);
    k = 0;
    while (!bus.timeout_err && k < 400) begin
      @(negedge clock);
      k++;
    end
    chk("lock_timeout_delay", 32'(k), 32'd255);
    chk("lock_release_cs_n", 32'(bus.cs_n), 32'hF);
    repeat (6) @(negedge clock);

    // Round-robin with all four clients requesting
    push_ack(0, 8'hC0);
    push_ack(1, 8'hC1);
    push_ack(2, 8'hC2);
    push_ack(3, 8'hC3);
    push_ack(0, 8'hC4);
    fork
      begin
        drive(0, 8'hC0, 1'b1);
        drive(0, 8'hC4, 1'b1);
      end
      drive(1, 8'hC1, 1'b1);
      drive(2, 8'hC2, 1'b1);
      drive(3, 8'hC3, 1'b1);
    join
    repeat (6) @(negedge clock);

    // Engine never signals done
    eng_mute = 1'b1;
    push_to();
    bus.req[2]       = 1'b1;
    bus.wdata[23:16] = 8'h5A;
    bus.last[2]      = 1'b1;
    @(negedge clock);
    chk("dto_load", 32'(bus.spi_load), 32'd1);
    k = 0;
    while (!bus.timeout_err && k < 1500) begin
      @(negedge clock);
      k++;
    end
    chk("done_timeout_delay", 32'(k), 32'd1023);
    chk("dto_load_drop", 32'(bus.spi_load), 32'd0);
    bus.req[2] = 1'b0;
    repeat (3) @(negedge clock);
    chk("dto_gap_busy", 32'(bus.busy), 32'd1);
    @(negedge clock);
    chk("dto_idle_busy", 32'(bus.busy), 32'd0);
    eng_mute = 1'b0;

    // Reset while a byte is loading
    bus.req[3]       = 1'b1;
    bus.wdata[31:24] = 8'hE7;
    bus.last[3]      = 1'b1;
    @(negedge clock);
    chk("mid_load", 32'(bus.spi_load), 32'd1);
    chk("mid_cs_n", 32'(bus.cs_n), 32'h7);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_load", 32'(bus.spi_load), 32'd0);
    chk("mid_rst_cs_n", 32'(bus.cs_n), 32'hF);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_ack", 32'(bus.ack), 32'd0);
    bus.req[3] = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Pointer restarts at 0 after reset
    push_ack(0, 8'h01);
    push_ack(3, 8'hE1);
    fork
      drive(0, 8'h01, 1'b1);
      drive(3, 8'hE1, 1'b1);
    join
    repeat (6) @(negedge clock);

    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
